// File: rtl/poseidon2_sched_pkg.sv
// Shared types and constants for the Poseidon2 job scheduler.
package poseidon2_sched_pkg;

  localparam int ELEM_W    = 256;
  localparam int SIZE_W    = 4;
  localparam int MAX_ELEMS = 15;
  localparam int ID_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    START,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ELEM_W-1:0] hash;
    logic              err;
  } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] w_cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr) + i >= NUM_REQ) w_cand = IDX_W'(int'(ptr) + i - NUM_REQ);
      else                          w_cand = IDX_W'(int'(ptr) + i);
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/poseidon2_job_sched.sv
// Round-robin job scheduler feeding the Poseidon2 core: collect operands,
// start the core, watch for done, and return a tagged response.
module poseidon2_job_sched
  import poseidon2_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [SIZE_W*NUM_REQ-1:0]   req_size,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        elem_valid,
  input  logic [ELEM_W-1:0]           elem_data,
  input  logic                        elem_last,
  output logic                        elem_ready,
  output logic                        core_start,
  output logic [SIZE_W-1:0]           core_size,
  output logic [ELEM_W*MAX_ELEMS-1:0] core_data,
  input  logic [ELEM_W-1:0]           core_hash,
  input  logic                        core_done,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic [ELEM_W-1:0]           resp_hash,
  output logic                        resp_err,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC);

  state_t              r_state, w_next;
  logic [NUM_REQ-1:0]  r_gnt, w_arb_gnt;
  logic [IDX_W-1:0]    r_rr_ptr, w_arb_idx;
  logic                w_arb_any;
  logic [SIZE_W-1:0]   r_size, r_cnt, w_win_size;
  logic [WD_W-1:0]     r_wd;
  logic [ELEM_W-1:0]   r_buf [MAX_ELEMS];
  resp_t               r_resp;
  logic                w_last_slot, w_timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (req),
    .ptr (r_rr_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  assign w_win_size  = req_size[w_arb_idx*SIZE_W +: SIZE_W];
  assign w_last_slot = (r_cnt == r_size - 1'b1);
  assign w_timeout   = (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (|req) w_next = ARB;
      ARB: begin
        if (!w_arb_any)             w_next = IDLE;
        else if (w_win_size == '0)  w_next = RESP;
        else                        w_next = LOAD;
      end
      LOAD: begin
        if (elem_valid) begin
          if (elem_last && w_last_slot)      w_next = START;
          else if (elem_last || w_last_slot) w_next = RESP;
        end
      end
      START: w_next = WAIT;
      WAIT:  if (core_done || w_timeout) w_next = RESP;
      RESP:  if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the operand buffer is reset because its contents drive core_data, which must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
      r_wd     <= '0;
      r_resp   <= '0;
      for (int k = 0; k < MAX_ELEMS; k++) r_buf[k] <= '0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_arb_any) begin
            r_gnt       <= (w_win_size != '0) ? w_arb_gnt : '0;
            r_size      <= w_win_size;
            r_cnt       <= '0;
            r_rr_ptr    <= (int'(w_arb_idx) == NUM_REQ - 1) ? '0 : w_arb_idx + 1'b1;
            r_resp.id   <= ID_W'(w_arb_idx);
            r_resp.hash <= '0;
            r_resp.err  <= (w_win_size == '0);
            for (int k = 0; k < MAX_ELEMS; k++) r_buf[k] <= '0;
          end
        end
        LOAD: begin
          if (elem_valid) begin
            r_buf[r_cnt] <= elem_data;
            r_cnt        <= r_cnt + 1'b1;
            if (elem_last || w_last_slot) r_gnt <= '0;
            // A last flag off the final slot, or a final slot without it, is a framing error.
            if (elem_last != w_last_slot) r_resp.err <= 1'b1;
          end
        end
        // Count from the start pulse so an expired job answers TIMEOUT_CYC cycles after it.
        START: r_wd <= WD_W'(1);
        WAIT: begin
          r_wd <= r_wd + 1'b1;
          if (core_done) begin
            r_resp.hash <= core_hash;
            r_resp.err  <= 1'b0;
          end else if (w_timeout) begin
            r_resp.hash <= '0;
            r_resp.err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < MAX_ELEMS; k++) begin : g_slot
    assign core_data[k*ELEM_W +: ELEM_W] = r_buf[k];
  end

  assign gnt        = r_gnt;
  assign elem_ready = (r_state == LOAD);
  assign core_start = (r_state == START);
  assign core_size  = r_size;
  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_resp.id;
  assign resp_hash  = r_resp.hash;
  assign resp_err   = r_resp.err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_poseidon2_job_sched.sv
// Randomized self-checking bench for poseidon2_job_sched against a job-level reference model.
module tb_poseidon2_job_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_size;
  logic [NREQ-1:0]   gnt;
  logic              elem_valid, elem_last, elem_ready;
  logic [255:0]      elem_data;
  logic              core_start, core_done;
  logic [3:0]        core_size;
  logic [256*15-1:0] core_data;
  logic [255:0]      core_hash;
  logic              resp_valid, resp_ready, resp_err, busy;
  logic [2:0]        resp_id;
  logic [255:0]      resp_hash;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start = 0;
  int model_ptr = 0;
  logic [255:0] exp_slot [15];

  poseidon2_job_sched #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_size(req_size), .gnt(gnt),
    .elem_valid(elem_valid), .elem_data(elem_data), .elem_last(elem_last),
    .elem_ready(elem_ready), .core_start(core_start), .core_size(core_size),
    .core_data(core_data), .core_hash(core_hash), .core_done(core_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_hash(resp_hash), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (core_start === 1'b1) n_start++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference grant: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_elem_ready"}, elem_ready, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_size"}, core_size, 0);
    check({tag, "_core_data_any"}, |core_data, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_id"}, resp_id, 0);
    check({tag, "_resp_hash"}, resp_hash, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One full job. last_at<0 means a well-formed frame; done_at<0 means the core never answers.
  task automatic do_job(input logic [NREQ-1:0] reqv, input logic [4*NREQ-1:0] sizes,
                        input int last_at, input int done_at, input logic [255:0] hash,
                        input int hold_cyc, input bit seq_data, input bit keep_req);
    int w, sz, la, b, lat, st, starts0;
    bit ok, tmo, fin;
    logic [255:0] d, exp_hash;
    logic exp_err;
    w         = pick(reqv, model_ptr);
    model_ptr = (w + 1) % NREQ;
    sz        = int'(sizes[w*4 +: 4]);
    la        = (last_at < 0) ? sz - 1 : last_at;
    ok        = (sz != 0) && (la == sz - 1);
    tmo       = !(done_at >= 1 && done_at <= TMO - 1);
    exp_err   = !ok || tmo;
    exp_hash  = exp_err ? '0 : hash;
    for (int k = 0; k < 15; k++) exp_slot[k] = '0;
    starts0   = n_start;

    req      = reqv;
    req_size = sizes;
    step();
    check("busy_arb", busy, 1);
    step();
    if (!keep_req) req = '0;
    if (sz == 0) begin
      check("size0_resp_after_2", resp_valid, 1);
      check("size0_gnt", gnt, 0);
      check("size0_no_start", n_start - starts0, 0);
    end else begin
      check("gnt_onehot", gnt, 256'(4'b0001 << w));
      b   = 0;
      fin = 1'b0;
      while (!fin) begin
        if ($urandom_range(0, 3) == 0) begin
          elem_valid = 1'b0;
          elem_data  = rnd256();
          step();
        end else begin
          d          = seq_data ? 256'(b + 1) : rnd256();
          elem_valid = 1'b1;
          elem_data  = d;
          elem_last  = (b == la);
          check("elem_ready", elem_ready, 1);
          exp_slot[b] = d;
          step();
          fin = (b == la) || (b == sz - 1);
          b++;
        end
      end
      elem_valid = 1'b0;
      elem_last  = 1'b0;
      check("gnt_drop", gnt, 0);
      if (ok) begin
        check("core_start", core_start, 1);
        check("core_size", core_size, 256'(sz));
        for (int k = 0; k < 15; k++) check($sformatf("slot%0d", k), core_data[k*256 +: 256], exp_slot[k]);
        st  = cyc;
        lat = -1;
        for (int j = 0; j < TMO + 8 && lat < 0; j++) begin
          core_done = (cyc - st == done_at);
          core_hash = core_done ? hash : rnd256();
          step();
          if (resp_valid) lat = cyc - st;
        end
        core_done = 1'b0;
        check("resp_latency_from_start", 256'(lat), 256'(tmo ? TMO : done_at + 1));
        check("start_pulses", 256'(n_start - starts0), 1);
        check("core_size_hold", core_size, 256'(sz));
        check("slot0_hold", core_data[255:0], exp_slot[0]);
      end else begin
        check("frame_resp", resp_valid, 1);
        check("frame_no_start", 256'(n_start - starts0), 0);
      end
    end

    for (int h = 0; h <= hold_cyc; h++) begin
      check("resp_valid", resp_valid, 1);
      check("resp_id", resp_id, 256'(w));
      check("resp_hash", resp_hash, exp_hash);
      check("resp_err", resp_err, exp_err);
      resp_ready = (h == hold_cyc);
      step();
    end
    resp_ready = 1'b0;
    check("resp_release", resp_valid, 0);
    check("idle_after_resp", busy, keep_req ? busy : 1'b0);
    if (!keep_req) req = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req_size   = '0;
    elem_valid = 1'b0;
    elem_data  = '0;
    elem_last  = 1'b0;
    core_hash  = '0;
    core_done  = 1'b0;
    resp_ready = 1'b0;
    repeat (2) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // Held all-request traffic, size 1 each: grants rotate 0,1,2,3.
    for (int i = 0; i < 4; i++)
      do_job(4'b1111, 16'h1111, -1, 3, rnd256(), 0, 1'b0, i < 3);

    // Directed three-element job from requester 1.
    do_job(4'b0010, 16'h0030, -1, 4, 256'hABCD, 1, 1'b1, 1'b0);
    // Pointer now 2: requesters 0 and 1 asking must give 0.
    do_job(4'b0011, 16'h0022, -1, 2, rnd256(), 0, 1'b0, 1'b0);
    // Zero-size request.
    do_job(4'b0100, 16'h0000, -1, 2, rnd256(), 0, 1'b0, 1'b0);
    // Early last on the second of four beats, then a clean size-2 job.
    do_job(4'b1000, 16'h4000, 1, 2, rnd256(), 0, 1'b0, 1'b0);
    do_job(4'b1000, 16'h2000, -1, 3, rnd256(), 0, 1'b0, 1'b0);
    // Core silent until timeout, then done on the final allowed cycle.
    do_job(4'b0001, 16'h0002, -1, -1, rnd256(), 0, 1'b0, 1'b0);
    do_job(4'b0001, 16'h0002, -1, TMO - 1, rnd256(), 0, 1'b0, 1'b0);
    // Consumer stalls the response for ten cycles.
    do_job(4'b0010, 16'h0010, -1, 5, rnd256(), 10, 1'b0, 1'b0);

    // Reset while the core is being waited on.
    req      = 4'b0100;
    req_size = 16'h0100;
    step();
    step();
    req        = '0;
    elem_valid = 1'b1;
    elem_last  = 1'b1;
    elem_data  = rnd256();
    step();
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    step();
    step();
    check("wait_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    step();
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        core_done = (i == 1);
        step();
        seen |= resp_valid;
      end
      core_done = 1'b0;
      check("no_resp_after_reset", seen, 0);
    end
    model_ptr = 0;
    do_job(4'b1111, 16'h1111, -1, 2, rnd256(), 0, 1'b0, 1'b0);

    // Randomized jobs.
    for (int n = 0; n < 24; n++) begin
      logic [NREQ-1:0] rv;
      logic [15:0] sv;
      int la, da, r;
      rv = NREQ'($urandom_range(1, 15));
      sv = 16'($urandom);
      r  = $urandom_range(0, 9);
      la = (r < 7) ? -1 : $urandom_range(0, 15);
      r  = $urandom_range(0, 9);
      da = (r == 0) ? -1 : (r == 1) ? TMO - 1 : $urandom_range(1, 10);
      do_job(rv, sv, la, da, rnd256(), $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
